// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider: request side (E, START, SGN, A, B)
// driven by the master, result side (Q, REM, BUSY, DONE, DZ, OV) by the divider.
interface seq_divider_if #(
    parameter int C_NUM_BITS = 8
);
    logic                  E;
    logic                  START;
    logic                  SGN;
    logic [C_NUM_BITS-1:0] A;
    logic [C_NUM_BITS-1:0] B;
    logic [C_NUM_BITS-1:0] Q;
    logic [C_NUM_BITS-1:0] REM;
    logic                  BUSY;
    logic                  DONE;
    logic                  DZ;
    logic                  OV;

    modport master (
        output E, START, SGN, A, B,
        input  Q, REM, BUSY, DONE, DZ, OV
    );

    modport slave (
        input  E, START, SGN, A, B,
        output Q, REM, BUSY, DONE, DZ, OV
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per enabled cycle, signed or
// unsigned per operation, with divide-by-zero and signed-overflow flags.
module seq_divider #(
    parameter int C_NUM_BITS = 8,
    parameter int C_CNT_BITS = $clog2(C_NUM_BITS + 1)
) (
    input  logic         CK,
    input  logic         R,
    seq_divider_if.slave bus
);
    localparam logic [C_NUM_BITS-1:0] MOST_NEG = {1'b1, {(C_NUM_BITS-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t                state;
    state_t                state_nxt;

    logic [C_NUM_BITS-1:0] b_abs;
    logic [C_NUM_BITS-1:0] quo;
    logic [C_NUM_BITS-1:0] rem_acc;
    logic [C_CNT_BITS-1:0] cnt;
    logic                  a_neg;
    logic                  q_neg;
    logic                  dz_pend;
    logic                  ov_pend;

    logic [C_NUM_BITS:0]   rem_ext;
    logic [C_NUM_BITS:0]   trial;
    logic                  step_bit;
    logic [C_NUM_BITS-1:0] step_rem;

    logic [C_NUM_BITS-1:0] q_r;
    logic [C_NUM_BITS-1:0] rem_r;
    logic                  done_r;
    logic                  dz_r;
    logic                  ov_r;

    function automatic logic [C_NUM_BITS-1:0] mag(input logic [C_NUM_BITS-1:0] v,
                                                  input logic sgn);
        return (sgn && v[C_NUM_BITS-1]) ? -v : v;
    endfunction

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent chains.
    always_ff @(posedge CK) begin
        if (R) begin
            state <= S_IDLE;
        end else if (bus.E) begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (bus.START) state_nxt = (bus.B == '0) ? S_FIX : S_RUN;
            S_RUN:  if (cnt == C_CNT_BITS'(1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Trial subtraction in N+1 bits: rem_ext < 2*|B|, so the top bit is a
    // reliable sign for the difference.
    always_comb begin
        rem_ext  = {rem_acc, quo[C_NUM_BITS-1]};
        trial    = rem_ext - {1'b0, b_abs};
        step_bit = ~trial[C_NUM_BITS];
        step_rem = step_bit ? trial[C_NUM_BITS-1:0] : rem_ext[C_NUM_BITS-1:0];
    end

    // NOTE: working registers carry no reset; they are always loaded on an
    // accepted START before being read, and leaving them out keeps reset fanout
    // off the datapath.
    always_ff @(posedge CK) begin
        if (bus.E) begin
            unique case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        b_abs   <= mag(bus.B, bus.SGN);
                        // Divide-by-zero skips RUN and reports the raw dividend.
                        quo     <= (bus.B == '0) ? bus.A : mag(bus.A, bus.SGN);
                        rem_acc <= '0;
                        cnt     <= C_CNT_BITS'(C_NUM_BITS);
                        a_neg   <= bus.SGN & bus.A[C_NUM_BITS-1];
                        q_neg   <= bus.SGN & (bus.A[C_NUM_BITS-1] ^ bus.B[C_NUM_BITS-1]);
                        dz_pend <= (bus.B == '0);
                        ov_pend <= bus.SGN && (bus.A == MOST_NEG) && (bus.B == '1);
                    end
                end
                S_RUN: begin
                    rem_acc <= step_rem;
                    quo     <= {quo[C_NUM_BITS-2:0], step_bit};
                    cnt     <= cnt - C_CNT_BITS'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (R) begin
            q_r    <= '0;
            rem_r  <= '0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            ov_r   <= 1'b0;
        end else if (bus.E) begin
            done_r <= 1'b0;
            if (state == S_FIX) begin
                done_r <= 1'b1;
                dz_r   <= dz_pend;
                ov_r   <= ov_pend;
                if (dz_pend) begin
                    q_r   <= '1;
                    rem_r <= quo;
                end else begin
                    q_r   <= q_neg ? -quo : quo;
                    rem_r <= a_neg ? -rem_acc : rem_acc;
                end
            end
        end
    end

    assign bus.Q    = q_r;
    assign bus.REM  = rem_r;
    assign bus.BUSY = (state != S_IDLE);
    assign bus.DONE = done_r;
    assign bus.DZ   = dz_r;
    assign bus.OV   = ov_r;
endmodule
